// File: rtl/detect_top.sv
// detect_top -- detection front-end board top (single clk domain).
//
// Drives the ADC/DAC converter clocks (clk/2) and loops each ADC sample back
// to the DAC. A debounced push key starts the capture of SAMPLES ADC bytes.
// The captured block then goes out as one raw Ethernet frame on GMII TX.
// The block also drives the PHY reset, a parked MDIO port and a status LED.
//
// Optional feature macro: ETH_FCS_EN
//   defined   : a CRC-32 FCS is appended (frame = 26+SAMPLES bytes)
//   undefined : no FCS and no CRC logic (frame = 22+SAMPLES bytes)
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   daclk, adclk     converter clocks = clk/2, in phase with each other
//   dadata           DAC data = last ADC sample, one clk after the adclk rise
//   addata           ADC sample input
//   enADC            ADC enable, high from the first clk after reset
//   key_in           asynchronous push key, active-high
//   temp_led         toggles on every accepted capture
//   e_reset          PHY reset, active-low, held PHY_RST_CYC clks after rst
//   e_mdc / e_mdio   free-running MDC, MDIO parked at high-Z
//   e_rxc            PHY RX clock, unused
//   e_gtxc           GMII TX clock (inverted clk, data centred on its rise)
//   e_txen/txer/txd  GMII transmit
module detect_top #(
  parameter int          SAMPLES     = 64,
  parameter int          DEB_CYCLES  = 500000,
  parameter int          PHY_RST_CYC = 1000,
  parameter int          MDC_DIV     = 20,
  parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_01_02_03,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
  input  logic       clk,
  input  logic       rst,
  output logic       daclk,
  output logic [7:0] dadata,
  output logic       adclk,
  input  logic [7:0] addata,
  output logic       enADC,
  input  logic       key_in,
  output logic       temp_led,
  output logic       e_reset,
  output logic       e_mdc,
  inout  wire        e_mdio,
  input  logic       e_rxc,
  output logic       e_gtxc,
  output logic       e_txen,
  output logic       e_txer,
  output logic [7:0] e_txd
);

`ifdef ETH_FCS_EN
  localparam int FCS_LEN = 4;
`else
  localparam int FCS_LEN = 0;
`endif
  localparam int HDR_LEN = 22;                      // preamble+SFD+dest+src+type
  localparam int FRAME   = HDR_LEN + SAMPLES + FCS_LEN;
  localparam int BW      = $clog2(FRAME + 1);
  localparam int IW      = $clog2(SAMPLES);
  localparam int LW      = $clog2(DEB_CYCLES + 1);
  localparam int PW      = $clog2(PHY_RST_CYC + 1);
  localparam int MW      = $clog2(MDC_DIV + 1);

  typedef enum logic [1:0] {IDLE, CAPT, SEND, GAP} state_t;

  state_t          state_q, state_d;
  logic            tgl_q, tgl_d;
  logic [7:0]      smp_q, smp_d;
  logic [7:0]      dadata_q, dadata_d;
  logic            en_q, en_d;
  logic [PW-1:0]   phy_cnt_q, phy_cnt_d;
  logic            e_reset_q, e_reset_d;
  logic [MW-1:0]   mdc_cnt_q, mdc_cnt_d;
  logic            mdc_q, mdc_d;
  logic            k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic            led_q, led_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [3:0]      gcnt_q, gcnt_d;
  logic            txen_q, txen_d;
  logic [7:0]      txd_q, txd_d;
  logic            accept, wr_en;
  logic [7:0]      tx_byte;
  logic [IW-1:0]   rd_idx;
  logic [47:0]     mac_sh;
  logic [7:0]      smp_mem [SAMPLES];
  logic            unused_rxc;

  assign unused_rxc = e_rxc;

`ifdef ETH_FCS_EN
  logic [31:0] crc_q, crc_d, fcs_sh;

  // Reflected CRC-32, data bits consumed LSB first.
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction
`endif

  // Byte on the wire for the current frame position.
  always_comb begin
    tx_byte = 8'h00;
    rd_idx  = '0;
    mac_sh  = SRC_MAC >> {BW'(19) - bcnt_q, 3'b000};
`ifdef ETH_FCS_EN
    fcs_sh  = ~crc_q >> {bcnt_q - BW'(HDR_LEN + SAMPLES), 3'b000};
`endif
    if (bcnt_q < BW'(7))                    tx_byte = 8'h55;
    else if (bcnt_q == BW'(7))              tx_byte = 8'hD5;
    else if (bcnt_q < BW'(14))              tx_byte = 8'hFF;
    else if (bcnt_q < BW'(20))              tx_byte = mac_sh[7:0];
    else if (bcnt_q == BW'(20))             tx_byte = ETHERTYPE[15:8];
    else if (bcnt_q == BW'(21))             tx_byte = ETHERTYPE[7:0];
    else if (bcnt_q < BW'(HDR_LEN + SAMPLES)) begin
      rd_idx  = IW'(bcnt_q - BW'(HDR_LEN));
      tx_byte = smp_mem[rd_idx];
    end
`ifdef ETH_FCS_EN
    else                                    tx_byte = fcs_sh[7:0];
`endif
  end

  always_comb begin
    // converter: sample on the edge where tgl goes 0->1, echo one clk later
    tgl_d    = ~tgl_q;
    smp_d    = tgl_q ? smp_q : addata;
    dadata_d = smp_q;
    en_d     = 1'b1;

    phy_cnt_d = phy_cnt_q;
    e_reset_d = e_reset_q;
    if (!e_reset_q) begin
      if (phy_cnt_q == PW'(PHY_RST_CYC - 1)) e_reset_d = 1'b1;
      else                                   phy_cnt_d = phy_cnt_q + PW'(1);
    end

    mdc_d     = mdc_q;
    mdc_cnt_d = mdc_cnt_q + MW'(1);
    if (mdc_cnt_q == MW'(MDC_DIV / 2 - 1)) begin
      mdc_cnt_d = '0;
      mdc_d     = ~mdc_q;
    end

    // key: 2-FF sync, edge detect, lockout not restarted by discarded edges
    k1_d   = key_in;
    k2_d   = k1_q;
    k3_d   = k2_q;
    accept = k2_q & ~k3_q & (lock_q == '0);
    lock_d = lock_q;
    if (accept)              lock_d = LW'(DEB_CYCLES);
    else if (lock_q != '0)   lock_d = lock_q - LW'(1);

    state_d = state_q;
    led_d   = led_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    wr_en   = 1'b0;
    txen_d  = 1'b0;
    txd_d   = 8'h00;
    case (state_q)
      IDLE: if (accept && e_reset_q) begin
        state_d = CAPT;
        led_d   = ~led_q;
        idx_d   = '0;
      end
      CAPT: if (!tgl_q) begin
        wr_en = 1'b1;
        if (idx_q == IW'(SAMPLES - 1)) begin
          state_d = SEND;
          bcnt_d  = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      SEND: begin
        txen_d = 1'b1;
        txd_d  = tx_byte;
        if (bcnt_q == BW'(FRAME - 1)) begin
          state_d = GAP;
          gcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      GAP: begin
        if (gcnt_q == 4'd11) state_d = IDLE;
        else                 gcnt_d  = gcnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

`ifdef ETH_FCS_EN
    // FCS covers dest..payload; seed while not sending
    crc_d = crc_q;
    if (state_q != SEND)
      crc_d = '1;
    else if (bcnt_q >= BW'(8) && bcnt_q < BW'(HDR_LEN + SAMPLES))
      crc_d = crc8(crc_q, tx_byte);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tgl_q     <= 1'b0;
      smp_q     <= 8'h00;
      dadata_q  <= 8'h00;
      en_q      <= 1'b0;
      phy_cnt_q <= '0;
      e_reset_q <= 1'b0;
      mdc_cnt_q <= '0;
      mdc_q     <= 1'b0;
      k1_q      <= 1'b0;
      k2_q      <= 1'b0;
      k3_q      <= 1'b0;
      lock_q    <= '0;
      led_q     <= 1'b0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      gcnt_q    <= '0;
      txen_q    <= 1'b0;
      txd_q     <= 8'h00;
`ifdef ETH_FCS_EN
      crc_q     <= '1;
`endif
    end else begin
      state_q   <= state_d;
      tgl_q     <= tgl_d;
      smp_q     <= smp_d;
      dadata_q  <= dadata_d;
      en_q      <= en_d;
      phy_cnt_q <= phy_cnt_d;
      e_reset_q <= e_reset_d;
      mdc_cnt_q <= mdc_cnt_d;
      mdc_q     <= mdc_d;
      k1_q      <= k1_d;
      k2_q      <= k2_d;
      k3_q      <= k3_d;
      lock_q    <= lock_d;
      led_q     <= led_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      gcnt_q    <= gcnt_d;
      txen_q    <= txen_d;
      txd_q     <= txd_d;
`ifdef ETH_FCS_EN
      crc_q     <= crc_d;
`endif
    end
  end

  // capture buffer: plain storage, contents only meaningful after CAPT
  always_ff @(posedge clk) begin
    if (wr_en) smp_mem[idx_q] <= addata;
  end

  assign adclk    = tgl_q;
  assign daclk    = tgl_q;
  assign dadata   = dadata_q;
  assign enADC    = en_q;
  assign temp_led = led_q;
  assign e_reset  = e_reset_q;
  assign e_mdc    = mdc_q;
  assign e_mdio   = 1'bz;
  assign e_gtxc   = ~clk;
  assign e_txen   = txen_q;
  assign e_txer   = 1'b0;
  assign e_txd    = txd_q;

endmodule

// File: tb/tb_detect_top.sv
module tb_detect_top;
  localparam int S   = 64;
  localparam int DEB = 180;
  localparam int PHY = 50;
  localparam int MDC = 20;
`ifdef ETH_FCS_EN
  localparam int FCS = 4;
`else
  localparam int FCS = 0;
`endif
  localparam int FRAME = 22 + S + FCS;
  localparam logic [47:0] MAC = 48'h00_0A_35_01_02_03;
  localparam logic [15:0] ETY = 16'h88B5;

  logic       clk = 1'b0, rst = 1'b1, key_in = 1'b0, e_rxc = 1'b0;
  logic [7:0] addata = 8'h00;
  wire        daclk, adclk, enADC, temp_led, e_reset, e_mdc, e_gtxc, e_txen, e_txer;
  wire  [7:0] dadata, e_txd;
  wire        e_mdio;

  detect_top #(.SAMPLES(S), .DEB_CYCLES(DEB), .PHY_RST_CYC(PHY), .MDC_DIV(MDC),
               .SRC_MAC(MAC), .ETHERTYPE(ETY)) dut (
    .clk(clk), .rst(rst), .daclk(daclk), .dadata(dadata), .adclk(adclk),
    .addata(addata), .enADC(enADC), .key_in(key_in), .temp_led(temp_led),
    .e_reset(e_reset), .e_mdc(e_mdc), .e_mdio(e_mdio), .e_rxc(e_rxc),
    .e_gtxc(e_gtxc), .e_txen(e_txen), .e_txer(e_txer), .e_txd(e_txd));

  always #10 clk = ~clk;
  always #4 e_rxc = ~e_rxc;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- data source ----------------
  int dmode = 0;  // 0 const 8, 1 ramp, 2 random
  initial forever begin
    @(posedge clk); #1;
    case (dmode)
      0: addata = 8'h08;
      1: addata = addata + 8'd1;
      default: addata = 8'($urandom);
    endcase
  end

`ifdef ETH_FCS_EN
  function automatic logic [31:0] sw_crc(input logic [31:0] c, input logic [7:0] b);
    c ^= {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction
`endif

  // ---------------- reference model ----------------
  // Time is counted in clk edges. Key history gives the synchronized edge,
  // converter phase is the parity of edges since reset, frames are queued
  // as byte lists built straight from the frame layout.
  bit          mdl_live = 0, mdl_led = 0;
  bit          h1 = 0, h2 = 0, h3 = 0;
  longint      gcyc = 0, last_acc = -1000000, busy_end = 0;
  int          edge_n = 0, rel_n = 0, mode = 0, mdl_frames = 0, frames_seen = 0;
  logic [7:0]  last_smp = 0, exp_da = 0;
  logic [7:0]  smps[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  cur[$];

  task automatic build_frame();
    logic [7:0] fr[$];
    logic [31:0] c;
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fr.push_back(8'hFF);
    for (int i = 5; i >= 0; i--) fr.push_back(MAC[8*i +: 8]);
    fr.push_back(ETY[15:8]);
    fr.push_back(ETY[7:0]);
    foreach (smps[i]) fr.push_back(smps[i]);
    c = 32'hFFFF_FFFF;
`ifdef ETH_FCS_EN
    for (int i = 8; i < 22 + S; i++) c = sw_crc(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
`endif
    foreach (fr[i]) exp_bytes.push_back(fr[i]);
  endtask

  always @(posedge clk) begin
    bit odd, rise, acc, start;
    gcyc++;
    if (rst) begin
      mdl_live = 1; mdl_led = 0; h1 = 0; h2 = 0; h3 = 0;
      last_acc = -1000000; edge_n = 0; rel_n = 0; mode = 0;
      last_smp = 0; exp_da = 0;
      mdl_frames -= exp_bytes.size() / FRAME;
      exp_bytes.delete();
      smps.delete();
    end else begin
      edge_n++; rel_n++;
      odd   = (edge_n % 2) == 1;
      rise  = h2 && !h3;
      acc   = rise && (gcyc - last_acc > DEB);
      start = acc && mode == 0 && rel_n > PHY;
      if (acc) last_acc = gcyc;
      exp_da = last_smp;
      if (odd) last_smp = addata;
      if (start) begin
        mode = 1; mdl_led = ~mdl_led; smps.delete();
      end else if (mode == 1 && odd) begin
        smps.push_back(addata);
        if (smps.size() == S) begin
          build_frame();
          mdl_frames++;
          mode = 2;
          busy_end = gcyc + FRAME + 12;
        end
      end else if (mode == 2 && gcyc == busy_end) begin
        mode = 0;
      end
      h3 = h2; h2 = h1; h1 = key_in;
    end
  end

  // per-cycle output checks and frame scoreboard
  always @(negedge clk) begin
    if (mdl_live) begin
      check("adclk", adclk, edge_n % 2);
      check("daclk", daclk, edge_n % 2);
      check("dadata", dadata, exp_da);
      check("enADC", enADC, rel_n >= 1);
      check("e_reset", e_reset, rel_n >= PHY);
      check("temp_led", temp_led, mdl_led);
      check("e_txer", e_txer, 0);
      check("e_gtxc", e_gtxc, 1);
      if (!e_txen) check("e_txd_idle", e_txd, 0);
      if (rst) cur.delete();
      else if (e_txen) cur.push_back(e_txd);
      else if (cur.size() > 0) begin
        int bad_i;
        frames_seen++;
        check("frame_len", cur.size(), FRAME);
        if (exp_bytes.size() < FRAME) begin
          check("frame_expected", 0, 1);
        end else begin
          bad_i = -1;
          for (int i = 0; i < FRAME && i < cur.size(); i++)
            if (bad_i < 0 && cur[i] != exp_bytes[i]) bad_i = i;
          if (bad_i >= 0)
            $display("byte %0d got %02h expected %02h", bad_i, cur[bad_i], exp_bytes[bad_i]);
          check("frame_first_bad_byte", bad_i, -1);
          for (int i = 0; i < FRAME; i++) void'(exp_bytes.pop_front());
        end
        cur.delete();
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press();
    key_in = 1'b1; wait_cyc(10);
    key_in = 1'b0; wait_cyc(10);
  endtask

  task automatic reset_and_phy();
    int j;
    rst = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    check("rst_adclk", adclk, 0);
    check("rst_dadata", dadata, 0);
    check("rst_enADC", enADC, 0);
    check("rst_led", temp_led, 0);
    check("rst_e_reset", e_reset, 0);
    check("rst_e_mdc", e_mdc, 0);
    check("rst_e_txen", e_txen, 0);
    check("rst_e_txd", e_txd, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    j = 0;
    do begin
      @(posedge clk); @(negedge clk); j++;
      if (j == 1) check("enADC_first_clk", enADC, 1);
    end while (!e_reset && j < 10 * PHY);
    check("phy_reset_clks", j, PHY);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int pre;          // idle clks before the press
    bit exp_led;      // LED shortly after the press
    int exp_frames;   // frames completed when the press starts
  } step_t;
  step_t tbl[6];

  initial begin
    int p, prev, k;
    // press spacing 100/100/100/200/60 clks; lockout 180, one frame ~230 clks
    tbl[0] = '{10,  1'b1, 0};  // accepted -> capture
    tbl[1] = '{80,  1'b1, 0};  // in lockout, during CAPT
    tbl[2] = '{80,  1'b1, 0};  // lockout expired, FSM in SEND: dropped, reloads lockout
    tbl[3] = '{80,  1'b1, 1};  // FSM idle but lockout reloaded by the drop
    tbl[4] = '{180, 1'b0, 1};  // lockout over -> second frame
    tbl[5] = '{40,  1'b0, 1};  // during capture, locked

    reset_and_phy();

    // MDC period
    prev = e_mdc; k = 0;
    do begin @(negedge clk); k++; p = prev; prev = e_mdc; end while (!(!p && e_mdc) && k < 100);
    k = 0;
    do begin @(negedge clk); k++; p = prev; prev = e_mdc; end while (!(!p && e_mdc) && k < 100);
    check("mdc_period", k, MDC);
    @(posedge clk); #1;

    dmode = 0;
    for (int i = 0; i < 6; i++) begin
      wait_cyc(tbl[i].pre);
      check($sformatf("step%0d_frames", i), frames_seen, tbl[i].exp_frames);
      press();
      check($sformatf("step%0d_led", i), temp_led, tbl[i].exp_led);
    end
    wait_cyc(300);
    check("table_frames_total", frames_seen, 2);

    dmode = 1;        // ramp: dadata tracked every cycle by the model
    wait_cyc(40);

    // reset in the middle of a frame
    dmode = 2;
    wait_cyc(200);
    press();
    k = 0;
    while (!e_txen && k < 400) begin @(negedge clk); k++; end
    check("txen_seen_before_reset", e_txen, 1);
    wait_cyc(20);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("txen_after_mid_rst", e_txen, 0);
    check("txd_after_mid_rst", e_txd, 0);
    reset_and_phy();
    wait_cyc(300);
    check("no_resume_after_rst", e_txen, 0);

    // randomized presses against the model
    for (int i = 0; i < 10; i++) begin
      wait_cyc($urandom_range(10, 300));
      press();
    end
    wait_cyc(400);
    check("rand_frames", frames_seen, mdl_frames);
    check("rand_queue_empty", exp_bytes.size(), 0);
    check("rand_led", temp_led, mdl_led);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
